// File: rtl/ysyx_220066_pc_fetch_pkg.sv
// Shared types and constants for the IF-stage PC/fetch sequencer.
package ysyx_220066_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        FLUSH
    } fetch_state_e;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ysyx_220066_pc_fetch.sv
// IF-stage PC register and single-outstanding fetch sequencer with EX redirect
// handling; stale responses for redirected fetches are absorbed in FLUSH.
module ysyx_220066_pc_fetch #(
    parameter int unsigned XLEN = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ysyx_220066_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic            id_misalign
);
    import ysyx_220066_pkg::*;

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst_q;
    logic            misalign_q;
    logic            pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= REQ;
            pc         <= RESET_PC;
            inst_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            unique case (state)
                REQ: begin
                    // A misaligned PC never reaches the bus; it is presented directly.
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= (pc_aligned && imem_req_ready) ? FLUSH : REQ;
                    end else if (!pc_aligned) begin
                        inst_q     <= '0;
                        misalign_q <= 1'b1;
                        state      <= HOLD;
                    end else if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= imem_resp_valid ? REQ : FLUSH;
                    end else if (imem_resp_valid) begin
                        inst_q     <= imem_resp_data;
                        misalign_q <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= REQ;
                    end else if (id_ready) begin
                        pc    <= pc + XLEN'(4);
                        state <= REQ;
                    end
                end
                FLUSH: begin
                    // The stale response is consumed even if a new redirect lands with it.
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end
                    if (imem_resp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    assign imem_req_valid = rst_n && (state == REQ) && pc_aligned;
    assign imem_req_addr  = pc;
    assign id_valid       = (state == HOLD);
    assign id_misalign    = (state == HOLD) && misalign_q;
    assign id_pc          = pc;
    assign id_inst        = inst_q;

endmodule

// File: tb/tb_ysyx_220066_pc_fetch.sv
// Scenario bench for the IF fetch sequencer: scoreboard of instructions expected at ID.
module tb_ysyx_220066_pc_fetch;
    import ysyx_220066_pkg::*;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } id_item_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n_w;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid, id_ready, id_misalign;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    logic        w_req_valid, w_id_valid, w_id_misalign;
    logic [63:0] w_req_addr, w_id_pc;
    logic [31:0] w_id_inst;

    int vectors = 0;
    int miscompares = 0;
    id_item_t sb[$];
    logic redir_q = 1'b0;

    always #5 clk = ~clk;

    ysyx_220066_pc_fetch u_dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_inst(id_inst), .id_misalign(id_misalign)
    );

    ysyx_220066_pc_fetch #(.XLEN(64), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(rst_n_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .id_valid(w_id_valid), .id_ready(id_ready), .id_pc(w_id_pc),
        .id_inst(w_id_inst), .id_misalign(w_id_misalign)
    );

    always @(posedge clk) redir_q <= redirect_valid && rst_n;

    // Scoreboard: every ID handshake (not cancelled by a redirect) must match the queue head.
    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready && !redirect_valid) begin
            id_item_t exp_item;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h, required no instruction", id_pc, id_inst);
            end else begin
                exp_item = sb.pop_front();
                if (id_pc !== exp_item.pc || id_inst !== exp_item.inst || id_misalign !== exp_item.mis) begin
                    miscompares++;
                    $display("FAIL sb_item: got pc=%h inst=%h mis=%b, required pc=%h inst=%h mis=%b",
                             id_pc, id_inst, id_misalign, exp_item.pc, exp_item.inst, exp_item.mis);
                end
            end
        end
        if (redir_q) begin
            vectors++;
            if (id_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL valid_after_redirect: got id_valid=%b, required 0", id_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [63:0] a, input logic [31:0] d);
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
            miscompares++;
            $display("FAIL fetch_req: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, a);
        end
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_wait: got req_valid=%b id_valid=%b, required 0 0", imem_req_valid, id_valid);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        sb.push_back('{pc: a, inst: d, mis: 1'b0});
        cyc();
        imem_resp_valid = 1'b0;
        imem_resp_data  = INST_NOP;
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== a || id_inst !== d || id_misalign !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_hold: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h", id_valid, id_pc, id_inst, a, d);
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== a + 64'd4) begin
            miscompares++;
            $display("FAIL fetch_next: got valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, a + 64'd4);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n_w = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = INST_NOP;
        id_ready = 1'b0;
        cyc(); cyc();
        vectors++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_misalign !== 1'b0 || id_inst !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b idv=%b mis=%b inst=%h, required 0 0 0 0", imem_req_valid, id_valid, id_misalign, id_inst);
        end
        vectors++;
        if (imem_req_addr !== RESET_PC || id_pc !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_pc: got addr=%h id_pc=%h, required %h", imem_req_addr, id_pc, RESET_PC);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_req: got %b, required 1", imem_req_valid);
        end
    endtask

    task automatic test_basic_fetch();
        fetch_one(RESET_PC, 32'h0000_0513);
    endtask

    task automatic test_redirect_wait();
        id_ready = 1'b1;
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        cyc();
        redirect_valid = 1'b0;
        cyc(); cyc();
        imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
        cyc();
        imem_resp_valid = 1'b0; imem_resp_data = INST_NOP;
        vectors++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
            miscompares++;
            $display("FAIL redirect_wait: got idv=%b req=%b addr=%h, required 0 1 %h", id_valid, imem_req_valid, imem_req_addr, 64'h8000_1000);
        end
        id_ready = 1'b0;
        fetch_one(64'h8000_1000, 32'h0010_0093);
    endtask

    task automatic test_redirect_handshake();
        id_ready = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        cyc();
        imem_req_ready = 1'b0; redirect_valid = 1'b0;
        cyc();
        vectors++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: got req=%b idv=%b, required 0 0", imem_req_valid, id_valid);
        end
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0001;
        cyc();
        imem_resp_valid = 1'b0; imem_resp_data = INST_NOP;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000 || id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_exit: got req=%b addr=%h idv=%b, required 1 %h 0", imem_req_valid, imem_req_addr, id_valid, 64'h8000_2000);
        end
        id_ready = 1'b0;
        fetch_one(64'h8000_2000, 32'h0020_0113);
    endtask

    task automatic test_hold_stall_redirect();
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0193;
        cyc();
        imem_resp_valid = 1'b0; imem_resp_data = INST_NOP;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (id_valid !== 1'b1 || id_pc !== 64'h8000_2004 || id_inst !== 32'h0030_0193) begin
                miscompares++;
                $display("FAIL hold_stable[%0d]: got v=%b pc=%h inst=%h, required 1 %h %h", i, id_valid, id_pc, id_inst, 64'h8000_2004, 32'h0030_0193);
            end
            cyc();
        end
        id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        cyc();
        redirect_valid = 1'b0; id_ready = 1'b0;
        vectors++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
            miscompares++;
            $display("FAIL hold_redirect: got idv=%b req=%b addr=%h, required 0 1 %h", id_valid, imem_req_valid, imem_req_addr, 64'h8000_0200);
        end
        fetch_one(64'h8000_0200, 32'h0040_0213);
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        cyc();
        redirect_valid = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_req: got req=%b idv=%b, required 0 0", imem_req_valid, id_valid);
        end
        cyc();
        vectors++;
        if (id_valid !== 1'b1 || id_misalign !== 1'b1 || id_pc !== 64'h8000_0102 || id_inst !== 32'h0 || imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL misalign_hold: got v=%b mis=%b pc=%h inst=%h req=%b, required 1 1 %h 0 0", id_valid, id_misalign, id_pc, id_inst, imem_req_valid, 64'h8000_0102);
        end
        sb.push_back('{pc: 64'h8000_0102, inst: 32'h0, mis: 1'b1});
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b0 || id_pc !== 64'h8000_0106) begin
            miscompares++;
            $display("FAIL misalign_next: got req=%b pc=%h, required 0 %h", imem_req_valid, id_pc, 64'h8000_0106);
        end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        cyc();
        redirect_valid = 1'b0;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0300) begin
            miscompares++;
            $display("FAIL misalign_recover: got req=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, 64'h8000_0300);
        end
    endtask

    task automatic test_reset_in_wait();
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_wait_req: got req=%b addr=%h, required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAAD_F00D;
        cyc();
        imem_resp_valid = 1'b0; imem_resp_data = INST_NOP;
        vectors++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset_stray_resp: got idv=%b req=%b addr=%h, required 0 1 %h", id_valid, imem_req_valid, imem_req_addr, RESET_PC);
        end
        fetch_one(RESET_PC, 32'h0050_0293);
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        cyc();
        rst_n_w = 1'b1;
        #1;
        vectors++;
        if (w_req_valid !== 1'b1 || w_req_addr !== WRAP_PC) begin
            miscompares++;
            $display("FAIL wrap_req: got req=%b addr=%h, required 1 %h", w_req_valid, w_req_addr, WRAP_PC);
        end
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0513;
        cyc();
        imem_resp_valid = 1'b0; imem_resp_data = INST_NOP;
        vectors++;
        if (w_id_valid !== 1'b1 || w_id_pc !== WRAP_PC || w_id_inst !== 32'h0000_0513) begin
            miscompares++;
            $display("FAIL wrap_hold: got v=%b pc=%h inst=%h, required 1 %h 00000513", w_id_valid, w_id_pc, w_id_inst, WRAP_PC);
        end
        id_ready = 1'b1;
        cyc();
        id_ready = 1'b0;
        vectors++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 64'h0) begin
            miscompares++;
            $display("FAIL wrap_next: got req=%b addr=%h, required 1 0", w_req_valid, w_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect_wait();
        test_redirect_handshake();
        test_hold_stall_redirect();
        test_misalign();
        test_reset_in_wait();
        test_wrap();
        cyc();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
